bnn_cmd_controller: RTL and testbench

//  Byte-level command controller for the BNN. Sits between the UART rx/tx byte

---
 rtl/bnn_cmd_if.sv | 38 +++
 rtl/bnn_cmd_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_bnn_cmd_controller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_cmd_if.sv
// Bus bundle between the BNN command controller and its surroundings
// (UART rx/tx byte streams, BNN input buffer, BNN core control).
//   master : the controller (drives cts, tx, image writes, start, busy)
//   slave  : the environment (drives rx, tx_ready, done, result)
// Parameters: IMG_BYTES sets the image address width, RESULT_BYTES the
// width of the BNN result.
interface bnn_cmd_if #(
    parameter int IMG_BYTES    = 16,
    parameter int RESULT_BYTES = 1
);
    localparam int ADDR_W = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;

    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic                      uart_cts;
    logic [7:0]                tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic                      img_wr_en;
    logic [ADDR_W-1:0]         img_wr_addr;
    logic [7:0]                img_wr_data;
    logic                      bnn_start;
    logic                      bnn_done;
    logic [8*RESULT_BYTES-1:0] bnn_result;
    logic                      busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, bnn_done, bnn_result,
        output uart_cts, tx_data, tx_valid, img_wr_en, img_wr_addr,
               img_wr_data, bnn_start, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bnn_done, bnn_result,
        input  uart_cts, tx_data, tx_valid, img_wr_en, img_wr_addr,
               img_wr_data, bnn_start, busy
    );
endinterface

// File: rtl/bnn_cmd_controller.sv
// Byte-level command controller for the BNN: parses host commands from the
// UART, streams image bytes into the BNN input buffer, launches inference
// and returns ACK/NAK/status/result bytes. Drives CTS for host flow control.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-low
//   bus  - bnn_cmd_if master modport (rx/tx bytes, cts, image writes,
//          bnn start/done/result, busy)
// Optional feature: define BNN_CHECKSUM_EN to require a trailing XOR
// checksum byte after the image payload of each LOAD command.
//
// state       | meaning
// ------------+------------------------------------------------------
// S_IDLE      | waiting for a command byte
// S_LOAD      | receiving image bytes (inter-byte timeout active)
// S_RUN       | single-cycle bnn_start pulse
// S_WAIT_DONE | waiting for bnn_done, result latched on it
// S_RESP      | shifting queued response bytes out on tx
module bnn_cmd_controller #(
    parameter int IMG_BYTES      = 16,
    parameter int RESULT_BYTES   = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic      clk,
    input  logic      rst,
    bnn_cmd_if.master bus
);
    localparam int ADDR_W = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
    localparam int RESP_W = 8 * (RESULT_BYTES + 1);
    localparam int RCNT_W = $clog2(RESULT_BYTES + 2);

    localparam logic [TMR_W-1:0]          TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RCNT_W-1:0]         RES_LEN  = RCNT_W'(RESULT_BYTES + 1);
    localparam logic [8*RESULT_BYTES-1:0] PAD      = '0;
`ifdef BNN_CHECKSUM_EN
    localparam logic [CNT_W-1:0]          CHK_IDX  = CNT_W'(IMG_BYTES);
`else
    localparam logic [CNT_W-1:0]          LAST_IDX = CNT_W'(IMG_BYTES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WAIT_DONE, S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                img_valid_q, img_valid_d;
    logic                timeout_err_q, timeout_err_d;
    logic                overrun_q, overrun_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                cts_q, cts_d;
`ifdef BNN_CHECKSUM_EN
    logic [7:0]          ck_q, ck_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        img_valid_d   = img_valid_q;
        timeout_err_d = timeout_err_q;
        overrun_d     = overrun_q;
        resp_d        = resp_q;
        rcnt_d        = rcnt_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        // CTS lags the state by one cycle.
        cts_d         = (state_q == S_IDLE) || (state_q == S_LOAD);
`ifdef BNN_CHECKSUM_EN
        ck_d          = ck_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    state_d = S_RESP;
                    rcnt_d  = RCNT_W'(1);
                    case (bus.rx_data)
                        8'hA1: begin
                            state_d     = S_LOAD;
                            cnt_d       = '0;
                            tmr_d       = TMR_LOAD;
                            img_valid_d = 1'b0;
`ifdef BNN_CHECKSUM_EN
                            ck_d        = 8'h00;
`endif
                        end
                        8'hA2: begin
                            if (img_valid_q) state_d = S_RUN;
                            else             resp_d  = {8'hE1, PAD};
                        end
                        8'hA3: begin
                            resp_d        = {{5'b0, overrun_q, timeout_err_q, img_valid_q}, PAD};
                            overrun_d     = 1'b0;
                            timeout_err_d = 1'b0;
                        end
                        default: resp_d = {8'hEE, PAD};
                    endcase
                end
            end
            S_LOAD: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (bus.rx_valid) begin
                    tmr_d = TMR_LOAD;
`ifdef BNN_CHECKSUM_EN
                    if (cnt_q == CHK_IDX) begin
                        state_d = S_RESP;
                        rcnt_d  = RCNT_W'(1);
                        if (bus.rx_data == ck_q) begin
                            img_valid_d = 1'b1;
                            resp_d      = {8'hAC, PAD};
                        end else begin
                            resp_d      = {8'hE2, PAD};
                        end
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[ADDR_W-1:0];
                        wr_data_d = bus.rx_data;
                        ck_d      = ck_q ^ bus.rx_data;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
`else
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = bus.rx_data;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        img_valid_d = 1'b1;
                        state_d     = S_RESP;
                        rcnt_d      = RCNT_W'(1);
                        resp_d      = {8'hAC, PAD};
                    end
`endif
                end else if (tmr_q == '0) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_RUN: state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.bnn_done) begin
                    state_d = S_RESP;
                    resp_d  = {8'h5A, bus.bnn_result};
                    rcnt_d  = RES_LEN;
                end
            end
            S_RESP: begin
                // Load a new byte when the slot is empty or the current one
                // transfers this cycle; otherwise tx_data holds.
                if (!tx_valid_q || bus.tx_ready) begin
                    if (rcnt_q != '0) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = resp_q[RESP_W-1 -: 8];
                        resp_d     = resp_q << 8;
                        rcnt_d     = rcnt_q - RCNT_W'(1);
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.rx_valid && (state_q == S_RUN || state_q == S_WAIT_DONE || state_q == S_RESP))
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tmr_q         <= '0;
            img_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            resp_q        <= '0;
            rcnt_q        <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 8'h00;
            cts_q         <= 1'b1;
`ifdef BNN_CHECKSUM_EN
            ck_q          <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            img_valid_q   <= img_valid_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            resp_q        <= resp_d;
            rcnt_q        <= rcnt_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            cts_q         <= cts_d;
`ifdef BNN_CHECKSUM_EN
            ck_q          <= ck_d;
`endif
        end
    end

    assign bus.uart_cts    = cts_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.img_wr_en   = wr_en_q;
    assign bus.img_wr_addr = wr_addr_q;
    assign bus.img_wr_data = wr_data_q;
    assign bus.bnn_start   = (state_q == S_RUN);
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_bnn_cmd_controller.sv
// Testbench for bnn_cmd_controller (IMG_BYTES=4, RESULT_BYTES=2,
// TIMEOUT_CYCLES=50). Expected tx bytes and image writes are queued by the
// stimulus and consumed by an independent monitor.
module tb_bnn_cmd_controller;
    localparam int IMG_BYTES      = 4;
    localparam int RESULT_BYTES   = 2;
    localparam int TIMEOUT_CYCLES = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bnn_cmd_if #(.IMG_BYTES(IMG_BYTES), .RESULT_BYTES(RESULT_BYTES)) bus();

    bnn_cmd_controller #(
        .IMG_BYTES(IMG_BYTES),
        .RESULT_BYTES(RESULT_BYTES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_wr[$];

    int          start_cnt   = 0;
    int          done_delay  = 5;
    logic [15:0] next_result = 16'h0000;
    int          spur_req    = 0;
    int          pend        = -1;
    int          spur_seen   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, transfers happen on the rising edge.
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] e8;
    logic [15:0] e16;
    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev)
                chk("tx_hold", {23'b0, bus.tx_valid, bus.tx_data}, {23'b0, 1'b1, stall_data});
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=%0h expected=none", bus.tx_data);
                end else begin
                    e8 = exp_tx.pop_front();
                    chk("tx_byte", {24'b0, bus.tx_data}, {24'b0, e8});
                end
            end
            if (bus.img_wr_en) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual=%0h/%0h expected=none",
                             bus.img_wr_addr, bus.img_wr_data);
                end else begin
                    e16 = exp_wr.pop_front();
                    chk("img_wr", {22'b0, bus.img_wr_addr, bus.img_wr_data}, {16'b0, e16});
                end
            end
            stall_prev <= bus.tx_valid && !bus.tx_ready;
            stall_data <= bus.tx_data;
        end else begin
            stall_prev <= 1'b0;
        end
    end

    // BNN core model: answers each start pulse after done_delay cycles;
    // spur_req changes inject a stray done pulse.
    initial begin
        bus.bnn_done   = 1'b0;
        bus.bnn_result = '0;
        forever begin
            @(posedge clk); #1;
            bus.bnn_done = 1'b0;
            if (bus.bnn_start) begin
                start_cnt++;
                pend = done_delay;
            end else if (pend > 0) begin
                pend--;
            end else if (pend == 0) begin
                bus.bnn_done   = 1'b1;
                bus.bnn_result = next_result;
                pend = -1;
            end
            if (spur_req != spur_seen) begin
                spur_seen      = spur_req;
                bus.bnn_done   = 1'b1;
                bus.bnn_result = 16'hDEAD;
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((bus.busy || bus.tx_valid || exp_tx.size() != 0 || exp_wr.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_done_in_time"}, {31'b0, n < 300}, 32'd1);
    endtask

    task automatic read_status(input string nm, input logic [7:0] exp);
        exp_tx.push_back(exp);
        send_byte(8'hA3);
        wait_idle(nm);
    endtask

    // Full image load expecting acceptance; bytes go out MS byte first.
    task automatic load_img(input string nm, input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_wr.push_back({8'(i), w[31-8*i -: 8]});
        exp_tx.push_back(8'hAC);
        send_byte(8'hA1);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
            gap(1);
        end
`ifdef BNN_CHECKSUM_EN
        send_byte(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
        wait_idle(nm);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        gap(3);
        chk("rst_cts",       {31'b0, bus.uart_cts},  32'd1);
        chk("rst_tx_valid",  {31'b0, bus.tx_valid},  32'd0);
        chk("rst_tx_data",   {24'b0, bus.tx_data},   32'd0);
        chk("rst_wr_en",     {31'b0, bus.img_wr_en}, 32'd0);
        chk("rst_wr_addr",   {30'b0, bus.img_wr_addr}, 32'd0);
        chk("rst_wr_data",   {24'b0, bus.img_wr_data}, 32'd0);
        chk("rst_bnn_start", {31'b0, bus.bnn_start}, 32'd0);
        chk("rst_busy",      {31'b0, bus.busy},      32'd0);
        rst = 1'b1;
        gap(2);

        // START without image -> E1, two-cycle response latency.
        exp_tx.push_back(8'hE1);
        send_byte(8'hA2);
        chk("lat_tx_valid_c1", {31'b0, bus.tx_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_tx_valid_c2", {31'b0, bus.tx_valid}, 32'd1);
        wait_idle("nak_e1");
        chk("no_start_unloaded", start_cnt, 0);
        exp_tx.push_back(8'hEE);
        send_byte(8'h7F);
        wait_idle("nak_ee");

        // LOAD, then status.
        load_img("load1", 32'h11223344);
        read_status("status_after_load", 8'h01);

        // Stray done in IDLE is ignored; START returns 5A + result.
        spur_req++;
        gap(5);
        chk("stray_done_busy", {31'b0, bus.busy}, 32'd0);
        next_result = 16'hBEEF;
        done_delay  = 5;
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hEF);
        send_byte(8'hA2);
        wait_idle("run1");
        chk("start_pulses_run1", start_cnt, 1);

        // Partial LOAD times out silently.
        exp_wr.push_back(16'h0011);
        exp_wr.push_back(16'h0122);
        send_byte(8'hA1);
        send_byte(8'h11);
        gap(1);
        send_byte(8'h22);
        gap(60);
        chk("timeout_busy", {31'b0, bus.busy},     32'd0);
        chk("timeout_cts",  {31'b0, bus.uart_cts}, 32'd1);
        read_status("status_timeout", 8'h02);
        read_status("status_cleared", 8'h00);

        // Overrun during WAIT_DONE and back-pressure on the result.
        load_img("load2", 32'hA5A55A5A);
        next_result = 16'h1234;
        done_delay  = 20;
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34);
        send_byte(8'hA2);
        gap(3);
        send_byte(8'h33);
        gap(1);
        chk("wait_busy", {31'b0, bus.busy},     32'd1);
        chk("wait_cts",  {31'b0, bus.uart_cts}, 32'd0);
        bus.tx_ready = 1'b0;
        begin
            int n = 0;
            while (!bus.tx_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("stall_tx_seen", {31'b0, n < 100}, 32'd1);
        end
        gap(10);
        bus.tx_ready = 1'b1;
        wait_idle("run2");
        chk("start_pulses_run2", start_cnt, 2);
        read_status("status_overrun", 8'h05);

`ifdef BNN_CHECKSUM_EN
        load_img("ck_good", 32'h01020408);
        read_status("status_ck_good", 8'h01);
        for (int i = 0; i < 4; i++) exp_wr.push_back({8'(i), 8'(1 << i)});
        exp_tx.push_back(8'hE2);
        send_byte(8'hA1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h04);
        send_byte(8'h08);
        send_byte(8'h00);
        wait_idle("ck_bad");
        read_status("status_ck_bad", 8'h00);
`endif

        gap(5);
        chk("exp_tx_drained", exp_tx.size(), 0);
        chk("exp_wr_drained", exp_wr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
